// File: rtl/imm_gen_stage_if.sv
// Beat-level bus for imm_gen_stage: upstream instruction lanes in, extended immediates out.
// The master side is the surrounding pipeline; the slave side is the decode stage itself.
interface imm_gen_stage_if #(
    parameter int LANES = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0][31:0]  instr;
    logic [LANES-1:0]        lane_en;
    logic [LANES-1:0]        zext;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES-1:0][31:0]  imm_out;
    logic [LANES-1:0]        fmt_err;

    modport master (
        output in_valid, instr, lane_en, zext, out_ready,
        input  in_ready, out_valid, imm_out, fmt_err
    );

    modport slave (
        input  in_valid, instr, lane_en, zext, out_ready,
        output in_ready, out_valid, imm_out, fmt_err
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Multi-lane RISC-V immediate generator feeding a small output FIFO,
// with a saturating count of lanes that carried an unsupported opcode.
module imm_gen_stage #(
    parameter int LANES = 2,
    parameter int DEPTH = 2,
    parameter int ERR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_gen_stage_if.slave    bus,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES-1:0][31:0] dec_imm;
    logic [LANES-1:0]       dec_err;
    logic [2:0]             err_inc;

    logic [LANES-1:0][31:0] imm_mem_q [DEPTH];
    logic [LANES-1:0][31:0] imm_mem_d [DEPTH];
    logic [LANES-1:0]       err_mem_q [DEPTH];
    logic [LANES-1:0]       err_mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;

    logic                   push;
    logic                   pop;
    logic [ERR_W-1:0]       err_base;
    logic [ERR_W:0]         err_sum;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0] w_l;
            logic        z_l;
            logic [31:0] imm_l;
            logic        err_l;

            assign w_l = bus.instr[gi];
            assign z_l = bus.zext[gi];

            always_comb begin
                imm_l = '0;
                err_l = 1'b0;
                if (bus.lane_en[gi]) begin
                    if (w_l[1:0] != 2'b11) begin
                        err_l = 1'b1;
                    end else begin
                        case (w_l[6:2])
                            5'b01101, 5'b00101: imm_l = {w_l[31:12], 12'b0};
                            5'b00100, 5'b00000: imm_l = {{20{w_l[31] & ~z_l}}, w_l[31:20]};
                            5'b11001:           imm_l = {{20{w_l[31]}}, w_l[31:20]};
                            5'b01000:           imm_l = {{20{w_l[31]}}, w_l[31:25], w_l[11:7]};
                            5'b11000:           imm_l = {{19{w_l[31] & ~z_l}}, w_l[31], w_l[7],
                                                         w_l[30:25], w_l[11:8], 1'b0};
                            5'b11011:           imm_l = {{11{w_l[31]}}, w_l[31], w_l[19:12],
                                                         w_l[20], w_l[30:21], 1'b0};
                            default:            err_l = 1'b1;
                        endcase
                    end
                end
            end

            assign dec_imm[gi]     = imm_l;
            assign dec_err[gi]     = err_l;
            assign bus.imm_out[gi] = imm_mem_q[rd_ptr_q][gi];
            assign bus.fmt_err[gi] = err_mem_q[rd_ptr_q][gi];
        end
    endgenerate

    always_comb begin
        err_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            err_inc = err_inc + 3'(dec_err[i]);
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready
    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign err_cnt       = err_cnt_q;

    always_comb begin
        imm_mem_d = imm_mem_q;
        err_mem_d = err_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_base  = err_clr ? '0 : err_cnt_q;
        err_sum   = {1'b0, err_base};

        if (push) begin
            imm_mem_d[wr_ptr_q] = dec_imm;
            err_mem_d[wr_ptr_q] = dec_err;
            wr_ptr_d            = wr_ptr_q + PW'(1);
            err_sum             = {1'b0, err_base} + (ERR_W+1)'(err_inc);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_cnt_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem_q[i] <= '0;
                err_mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            imm_mem_q <= imm_mem_d;
            err_mem_q <= err_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode vectors, FIFO back-pressure,
// error-count saturation/clear and mid-stream reset.
module tb_imm_gen_stage;
    localparam int LANES = 2;
    localparam int DEPTH = 2;
    localparam int ERR_W = 4;

    logic             clk;
    logic             rst_n;
    logic             err_clr;
    logic [ERR_W-1:0] err_cnt;
    int               n_tests;
    int               n_fail;
    int               exp_err;

    imm_gen_stage_if #(.LANES(LANES)) bus_if ();

    imm_gen_stage #(.LANES(LANES), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i0; logic e0; logic z0; logic [31:0] x0; logic f0;
        logic [31:0] i1; logic e1; logic z1; logic [31:0] x1; logic f1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i0, input logic e0, input logic z0,
                         input logic [31:0] i1, input logic e1, input logic z1);
        bus_if.instr[0]   = i0;
        bus_if.lane_en[0] = e0;
        bus_if.zext[0]    = z0;
        bus_if.instr[1]   = i1;
        bus_if.lane_en[1] = e1;
        bus_if.zext[1]    = z1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_err = 0;

        //            lane0 instr    en    zext  exp imm0       err   lane1 instr    en    zext  exp imm1       err
        vecs[0] = '{32'hFFF00093, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0000007F, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{32'hFFF00093, 1'b1, 1'b1, 32'h00000FFF, 1'b0, 32'hFE000EE3, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b0};
        vecs[2] = '{32'h12345037, 1'b1, 1'b0, 32'h12345000, 1'b0, 32'h800000EF, 1'b1, 1'b0, 32'hFFF00000, 1'b0};
        vecs[3] = '{32'hFFFFF017, 1'b1, 1'b0, 32'hFFFFF000, 1'b0, 32'hFE000EE3, 1'b1, 1'b1, 32'h00001FFC, 1'b0};
        vecs[4] = '{32'h80000067, 1'b1, 1'b1, 32'hFFFFF800, 1'b0, 32'h800000EF, 1'b1, 1'b1, 32'hFFF00000, 1'b0};
        vecs[5] = '{32'hFE000E23, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h7FF00003, 1'b1, 1'b0, 32'h000007FF, 1'b0};
        vecs[6] = '{32'h0000007F, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000091, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vecs[7] = '{32'h0000007F, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h80000003, 1'b1, 1'b1, 32'h00000800, 1'b0};

        rst_n            = 1'b0;
        err_clr          = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        #12;
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        check("rst_imm0",      bus_if.imm_out[0],     32'h0);
        check("rst_fmt_err",   32'(bus_if.fmt_err),   32'd0);
        check("rst_err_cnt",   32'(err_cnt),          32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // decode vectors, streaming with out_ready held high
        bus_if.out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].i0, vecs[v].e0, vecs[v].z0, vecs[v].i1, vecs[v].e1, vecs[v].z1);
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
            drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            exp_err = exp_err + int'(vecs[v].f0) + int'(vecs[v].f1);
            $display("[TB] vec %0d imm0=%h imm1=%h err=%b%b cnt=%0d",
                     v, bus_if.imm_out[0], bus_if.imm_out[1],
                     bus_if.fmt_err[1], bus_if.fmt_err[0], err_cnt);
            check($sformatf("v%0d_valid", v), 32'(bus_if.out_valid),  32'd1);
            check($sformatf("v%0d_imm0", v),  bus_if.imm_out[0],      vecs[v].x0);
            check($sformatf("v%0d_imm1", v),  bus_if.imm_out[1],      vecs[v].x1);
            check($sformatf("v%0d_err0", v),  32'(bus_if.fmt_err[0]), 32'(vecs[v].f0));
            check($sformatf("v%0d_err1", v),  32'(bus_if.fmt_err[1]), 32'(vecs[v].f1));
            check($sformatf("v%0d_cnt", v),   32'(err_cnt),           32'(exp_err));
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(bus_if.out_valid), 32'd0);

        // back-pressure: three beats offered, only two fit
        bus_if.out_ready = 1'b0;
        drive(32'h00001037, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        $display("[TB] push A in_ready=%0d", bus_if.in_ready);
        check("fill1_in_ready", 32'(bus_if.in_ready), 32'd1);
        drive(32'h00002037, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        $display("[TB] push B in_ready=%0d", bus_if.in_ready);
        check("fill2_in_ready", 32'(bus_if.in_ready), 32'd0);
        drive(32'h00003037, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        $display("[TB] hold C in_ready=%0d head=%h", bus_if.in_ready, bus_if.imm_out[0]);
        check("full_hold",   32'(bus_if.in_ready), 32'd0);
        check("full_head_A", bus_if.imm_out[0],    32'h00001000);

        // full with out_ready: pop only this edge, push+pop next edge
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        $display("[TB] pop A head=%h in_ready=%0d", bus_if.imm_out[0], bus_if.in_ready);
        check("pop_head_B",  bus_if.imm_out[0],    32'h00002000);
        check("pop_ready",   32'(bus_if.in_ready), 32'd1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        $display("[TB] push C pop B head=%h", bus_if.imm_out[0]);
        check("pp_head_C",   bus_if.imm_out[0],     32'h00003000);
        check("pp_valid",    32'(bus_if.out_valid), 32'd1);
        @(posedge clk); #1;
        check("pp_drained",  32'(bus_if.out_valid), 32'd0);

        // error counter saturation: 2^ERR_W beats with two bad lanes each
        drive(32'h0000007F, 1'b1, 1'b0, 32'h0000007F, 1'b1, 1'b0);
        bus_if.in_valid = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        $display("[TB] saturate err_cnt=%0d", err_cnt);
        check("err_sat", 32'(err_cnt), 32'hF);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        bus_if.in_valid = 1'b0;
        $display("[TB] clear on error beat err_cnt=%0d", err_cnt);
        check("err_clr_beat", 32'(err_cnt), 32'd2);
        @(posedge clk); #1;
        check("sat_drained", 32'(bus_if.out_valid), 32'd0);

        // fill buffer, offer a rejected error beat, then reset mid-stream
        bus_if.out_ready = 1'b0;
        drive(32'h00004037, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drive(32'h0000007F, 1'b1, 1'b0, 32'h0000007F, 1'b1, 1'b0);
        @(posedge clk); #1;
        $display("[TB] rejected error beat err_cnt=%0d in_ready=%0d", err_cnt, bus_if.in_ready);
        check("rej_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("rej_err_cnt",  32'(err_cnt),         32'd2);
        bus_if.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset out_valid=%0d in_ready=%0d err_cnt=%0d",
                 bus_if.out_valid, bus_if.in_ready, err_cnt);
        check("mrst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("mrst_in_ready",  32'(bus_if.in_ready),  32'd1);
        check("mrst_err_cnt",   32'(err_cnt),          32'd0);
        check("mrst_imm0",      bus_if.imm_out[0],     32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        bus_if.out_ready = 1'b1;
        drive(32'h00005037, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        $display("[TB] post-reset beat head=%h", bus_if.imm_out[0]);
        check("post_valid", 32'(bus_if.out_valid), 32'd1);
        check("post_imm0",  bus_if.imm_out[0],     32'h00005000);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 The block SHALL have parameter LANES, default 2, giving the number of instruction lanes decoded per beat (1..4).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the output buffer entries (power of two, >=2).
REQ-003 The block SHALL have parameter ERR_W, default 16, giving the error counter width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, an upstream beat is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, the block can accept a beat.
REQ-008 The block SHALL have port instr[LANES], input, 32 bits each, the raw instruction words.
REQ-009 The block SHALL have port lane_en[LANES], input, 1 bit each, the lane carries a live instruction.
REQ-010 The block SHALL have port zext[LANES], input, 1 bit each, zero-extend instead of sign-extend (I and B formats only).
REQ-011 The block SHALL have port out_valid, output, 1 bit, the buffer head is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, downstream accepts the head.
REQ-013 The block SHALL have port imm_out[LANES], output, 32 bits each, the extended immediates.
REQ-014 The block SHALL have port fmt_err[LANES], output, 1 bit each, the lane opcode is unsupported.
REQ-015 The block SHALL have port err_clr, input, 1 bit, synchronous clear of err_cnt.
REQ-016 The block SHALL have port err_cnt, output, ERR_W bits, saturating count of erroring lanes.

Function
REQ-017 Decode SHALL key on instr[6:2] per lane; an enabled lane with instr[1:0]!=2'b11 SHALL be treated as unsupported.
REQ-018 01101/00101 (LUI/AUIPC) SHALL produce {instr[31:12],12'b0}.
REQ-019 00100/00000 (OP-IMM/LOAD) SHALL extend instr[31:20] from bit 11; zext=1 SHALL fill the upper bits with zero.
REQ-020 11001 (JALR) SHALL sign-extend instr[31:20], ignoring zext.
REQ-021 01000 (STORE) SHALL sign-extend {instr[31:25],instr[11:7]}, ignoring zext.
REQ-022 11000 (BRANCH) SHALL produce {instr[31],instr[7],instr[30:25],instr[11:8],1'b0} extended from bit 12; zext applies.
REQ-023 11011 (JAL) SHALL sign-extend {instr[31],instr[19:12],instr[20],instr[30:21],1'b0} from bit 20.
REQ-024 Any other opcode on an enabled lane SHALL give imm_out=0 and fmt_err=1.
REQ-025 A disabled lane SHALL give imm_out=0 and fmt_err=0 regardless of instr.
REQ-026 A beat SHALL be accepted when in_valid&&in_ready; the decoded lanes SHALL be written to the buffer at that edge.
REQ-027 The buffer SHALL be a DEPTH-entry FIFO with occupancy count 0..DEPTH; in_ready SHALL equal (count<DEPTH), with no combinational path from out_ready.
REQ-028 A pop SHALL occur when out_valid&&out_ready; out_valid SHALL equal (count!=0); outputs SHALL be driven from registered head state.
REQ-029 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL appear at the head after edge N when the buffer was empty.
REQ-030 A simultaneous push and pop SHALL leave count unchanged and preserve order; pointers SHALL wrap modulo DEPTH.
REQ-031 On each accepted beat, err_cnt SHALL add the number of fmt_err lanes and saturate at 2^ERR_W-1.
REQ-032 err_clr SHALL load err_cnt with the current beat's increment (0 if no beat is accepted), so it has priority over the old value only.
REQ-033 A beat that is not accepted (in_ready=0) SHALL NOT affect err_cnt.

Reset
REQ-034 When rst_n=0, count, pointers and err_cnt SHALL clear asynchronously; out_valid=0, in_ready=1, imm_out=0, fmt_err=0.
REQ-035 A reset asserted mid-stream SHALL discard all buffered beats; the first beat after release SHALL be accepted normally.

Verification
REQ-036 Lane0 instr=32'hFFF00093 (addi), zext=0 -> imm_out[0]=32'hFFFFFFFF one cycle later; same with zext=1 -> 32'h00000FFF.
REQ-037 Lane1 instr=32'hFE000EE3 (beq -4) -> imm_out[1]=32'hFFFFFFFC; instr=32'h800000EF (jal) -> 32'hFFF00000.
REQ-038 Hold out_ready=0 and push 3 beats with DEPTH=2 -> in_ready=0 after 2 accepted beats, 3rd held, FIFO order kept on drain.
REQ-039 Full buffer with out_ready=1 and in_valid=1 -> pop only that cycle, push next cycle, no loss or duplication.
REQ-040 Both lanes enabled with opcode 7'b1111111 for 2^ERR_W beats -> err_cnt saturates at all-ones; err_clr on an error beat -> err_cnt=2.
REQ-041 rst_n pulsed low with 2 beats buffered -> out_valid=0 immediately, err_cnt=0, in_ready=1.
